// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: order-word field layout,
// order-list address width and the sequencer FSM states.
package song_pkg;

  localparam int ORD_AW       = 4;  // order-list ROM address width
  localparam int ORD_FIELD_W  = 5;  // width of each order-word field
  localparam int ORD_ADDR_LSB = 0;  // bits [4:0]: pattern start address
  localparam int ORD_LEN_LSB  = 5;  // bits [9:5]: pattern length code
  localparam int ORD_WORD_W   = 10;

  typedef struct packed {
    logic [ORD_FIELD_W-1:0] len;
    logic [ORD_FIELD_W-1:0] addr;
  } order_word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/tempo_divider.sv
// Note-step tempo counter: counts 0..CLK_DIV-1 while run is high and flags
// the terminal count as a tick. clear forces the count back to 0.
module tempo_divider #(
  parameter int CLK_DIV = 4000
) (
  input  logic i_clk,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  // Free-running modulo-CLK_DIV count, held while not running.
  always_ff @(posedge i_clk) begin
    if (clear)    count <= '0;
    else if (run) count <= (count == LAST) ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks an order list of patterns, fetching each entry from
// an external ROM and driving the note sequencer with a step strobe and a
// pattern-load pulse on the first step of every pattern.
// Optional feature: define SONG_SEQUENCER_LOOP_EN to loop the order list
// forever instead of stopping in DONE after the last entry.
module song_sequencer
  import song_pkg::*;
#(
  parameter int CLK_DIV   = 4000,
  parameter int ORDER_LEN = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  output logic [ORD_AW-1:0]      o_order_addr,
  input  logic [ORD_WORD_W-1:0]  i_order_data,
  output logic                   o_note_stb,
  output logic [ORD_FIELD_W-1:0] o_new_addr,
  output logic [ORD_FIELD_W-1:0] o_new_pattern_len,
  output logic                   o_new_addr_valid,
  output logic                   o_song_done
);

  localparam logic [ORD_AW-1:0] LAST_IDX = ORD_AW'(ORDER_LEN - 1);

  state_t                 state;
  logic [ORD_AW-1:0]      order_idx;
  logic [ORD_FIELD_W-1:0] step_cnt;
  logic                   first;
  order_word_t            pat;     // entry currently playing
  logic [ORD_FIELD_W-1:0] addr_q;  // last pattern handed to the note sequencer
  logic [ORD_FIELD_W-1:0] len_q;
  logic                   tick;
  logic                   run_cnt;
  logic                   play_tick;
  logic                   last_step;
  logic                   last_entry;

  // Tempo keeps running through FETCH/LOAD so pattern changes cost no time.
  assign run_cnt = (state == FETCH) || (state == LOAD) || (state == PLAY);

  tempo_divider #(.CLK_DIV(CLK_DIV)) u_tempo (
    .i_clk (i_clk),
    .clear (i_rst || (state == IDLE)),
    .run   (run_cnt),
    .tick  (tick)
  );

  // A dropped enable aborts this very cycle, so pulses are qualified by it.
  assign play_tick  = (state == PLAY) && tick && i_enable;
  assign last_step  = (step_cnt == pat.len);
  assign last_entry = (order_idx == LAST_IDX);

  assign o_note_stb        = play_tick;
  assign o_new_addr_valid  = play_tick && first;
  assign o_new_addr        = o_new_addr_valid ? pat.addr : addr_q;
  assign o_new_pattern_len = o_new_addr_valid ? pat.len  : len_q;
  assign o_song_done       = play_tick && last_step && last_entry;

  // Sequencer FSM: fetch entry, load it, play L+1 steps, move to next entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      order_idx    <= '0;
      step_cnt     <= '0;
      first        <= 1'b0;
      pat          <= '0;
      o_order_addr <= '0;
      addr_q       <= '0;
      len_q        <= '0;
    end else if (state != IDLE && !i_enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            order_idx    <= '0;
            o_order_addr <= '0;
            state        <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          pat.addr <= i_order_data[ORD_ADDR_LSB +: ORD_FIELD_W];
          pat.len  <= i_order_data[ORD_LEN_LSB +: ORD_FIELD_W];
          step_cnt <= '0;
          first    <= 1'b1;
          state    <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            if (first) begin
              addr_q <= pat.addr;
              len_q  <= pat.len;
              first  <= 1'b0;
            end
            if (last_step) begin
              if (last_entry) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                order_idx    <= '0;
                o_order_addr <= '0;
                state        <= FETCH;
`else
                state        <= DONE;
`endif
              end else begin
                order_idx    <= order_idx + ORD_AW'(1);
                o_order_addr <= order_idx + ORD_AW'(1);
                state        <= FETCH;
              end
            end else begin
              step_cnt <= step_cnt + ORD_FIELD_W'(1);
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a schedule-level model (strobe k of a run lands
// CLK_DIV*(k+1) cycles after the enabling cycle; which entry/step it is comes
// from the flattened order list) is compared every cycle, plus directed
// hand-computed strobe/load/done masks.
module tb_song_sequencer;
  localparam int CLK_DIV   = 4;
  localparam int ORDER_LEN = 2;
`ifdef SONG_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_enable = 1'b0;
  logic [3:0] o_order_addr;
  logic [9:0] i_order_data = '0;
  logic       o_note_stb;
  logic [4:0] o_new_addr;
  logic [4:0] o_new_pattern_len;
  logic       o_new_addr_valid;
  logic       o_song_done;

  song_sequencer #(.CLK_DIV(CLK_DIV), .ORDER_LEN(ORDER_LEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .o_order_addr(o_order_addr), .i_order_data(i_order_data),
    .o_note_stb(o_note_stb), .o_new_addr(o_new_addr),
    .o_new_pattern_len(o_new_pattern_len),
    .o_new_addr_valid(o_new_addr_valid), .o_song_done(o_song_done)
  );

  always #5 i_clk = ~i_clk;

  // Order ROM with one cycle of read latency.
  logic [9:0] rom [16];
  always @(posedge i_clk) i_order_data <= rom[o_order_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_OFF, M_RUN, M_FIN} mmode_t;
  mmode_t     mode = M_OFF;
  longint     cyc = 0;
  longint     t0 = 0;
  int         k = 0;
  logic [4:0] last_a = '0, last_l = '0;
  bit         hit, ev_ld, ev_dn;
  logic [4:0] ev_a, ev_l, ea, el;

  // Strobe number kk of a run -> which entry/step it plays.
  function automatic void get_ev(input int kk, output bit ld, output logic [4:0] a,
                                 output logic [4:0] l, output bit dn);
    int tot, idx, n;
    tot = 0;
    for (int e = 0; e < ORDER_LEN; e++) tot += int'(rom[e][9:5]) + 1;
    idx = LOOP ? (kk % tot) : kk;
    ld = 0; a = '0; l = '0; dn = 0;
    for (int e = 0; e < ORDER_LEN; e++) begin
      n = int'(rom[e][9:5]) + 1;
      if (idx < n) begin
        ld = (idx == 0);
        a  = rom[e][4:0];
        l  = rom[e][9:5];
        dn = (e == ORDER_LEN - 1) && (idx == n - 1);
        return;
      end
      idx -= n;
    end
  endfunction

  // Compare this cycle against the model, then advance the model past the edge.
  always @(negedge i_clk) begin
    cyc++;
    hit = (mode == M_RUN) && i_enable && !i_rst && (cyc - t0 == longint'(CLK_DIV * (k + 1)));
    ev_ld = 0; ev_dn = 0; ev_a = '0; ev_l = '0;
    if (hit) get_ev(k, ev_ld, ev_a, ev_l, ev_dn);
    if (!i_rst) begin
      ea = (hit && ev_ld) ? ev_a : last_a;
      el = (hit && ev_ld) ? ev_l : last_l;
      chk("cycle", {o_note_stb, o_new_addr_valid, o_song_done, o_new_addr, o_new_pattern_len},
                   {hit, hit && ev_ld, hit && ev_dn, ea, el});
    end
    if (i_rst) begin
      mode = M_OFF; last_a = '0; last_l = '0;
    end else if (mode != M_OFF && !i_enable) begin
      mode = M_OFF;
    end else if (mode == M_OFF && i_enable) begin
      mode = M_RUN; t0 = cyc; k = 0;
    end else if (hit) begin
      k++;
      if (ev_ld) begin last_a = ev_a; last_l = ev_l; end
      if (ev_dn && !LOOP) mode = M_FIN;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] a_stb, a_ld, a_dn, r;
  logic [4:0]  a_addr [32];
  logic [4:0]  a_len  [32];
  logic [5:0]  snap;
  int          quiet;

  task automatic tick1();
    @(posedge i_clk); #1;
  endtask

  // Reset, load two entries, enable, and record 31 cycles of outputs.
  task automatic go(input logic [9:0] e0, input logic [9:0] e1);
    i_rst = 1; i_enable = 0; rom[0] = e0; rom[1] = e1;
    tick1(); i_rst = 0;
    tick1(); i_enable = 1;
    a_stb = '0; a_ld = '0; a_dn = '0;
    for (int j = 1; j < 32; j++) begin
      tick1();
      a_stb[j] = o_note_stb; a_ld[j] = o_new_addr_valid; a_dn[j] = o_song_done;
      a_addr[j] = o_new_addr; a_len[j] = o_new_pattern_len;
    end
  endtask

  initial begin
    for (int e = 0; e < 16; e++) rom[e] = '0;
    i_rst = 1; i_enable = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    chk("reset_outs", {o_note_stb, o_new_addr_valid, o_song_done, o_new_addr, o_new_pattern_len, o_order_addr}, '0);

    // Entry0 {addr 3, L 2}, entry1 {addr 10, L 1}.
    go({5'd2, 5'd3}, {5'd1, 5'd10});
    chk("A_stb",  a_stb, LOOP ? 32'h11111110 : 32'h00111110);
    chk("A_load", a_ld,  LOOP ? 32'h01010010 : 32'h00010010);
    chk("A_done", a_dn,  32'h00100000);
    chk("A_pat4",  {a_addr[4],  a_len[4]},  {5'd3,  5'd2});
    chk("A_hold10", {a_addr[10], a_len[10]}, {5'd3,  5'd2});
    chk("A_pat16", {a_addr[16], a_len[16]}, {5'd10, 5'd1});

    // Drop enable, re-raise: restart from entry 0.
    i_enable = 0; tick1(); tick1(); i_enable = 1;
    r = '0;
    for (int j = 1; j <= 4; j++) begin tick1(); r[j] = o_note_stb; end
    chk("restart_stb", r, 32'h10);
    chk("restart_load", {o_new_addr_valid, o_new_addr}, {1'b1, 5'd3});

    // Reset in the middle of the pattern.
    tick1(); i_rst = 1; i_enable = 0;
    tick1(); i_rst = 0;
    chk("midrst_outs", {o_note_stb, o_new_addr_valid, o_song_done, o_new_addr, o_new_pattern_len, o_order_addr}, '0);
    quiet = 0;
    for (int j = 0; j < 10; j++) begin tick1(); quiet += int'(o_note_stb); end
    chk("midrst_quiet", quiet, 0);
    i_enable = 1;
    r = '0;
    for (int j = 1; j <= 6; j++) begin tick1(); r[j] = o_note_stb; end
    chk("midrst_first", r, 32'h10);

    // Entry0 {addr 0, L 0}, entry1 {addr 10, L 1}: back-to-back patterns.
    go({5'd0, 5'd0}, {5'd1, 5'd10});
    chk("B_stb",  a_stb, LOOP ? 32'h11111110 : 32'h00001110);
    chk("B_load", a_ld,  LOOP ? 32'h10110110 : 32'h00000110);
    chk("B_done", a_dn,  LOOP ? 32'h01001000 : 32'h00001000);
    chk("B_pat4", {a_addr[4], a_len[4]}, {5'd0,  5'd0});
    chk("B_pat8", {a_addr[8], a_len[8]}, {5'd10, 5'd1});

    // Randomized episodes: new ROM under reset, then random enable/reset.
    for (int ep = 0; ep < 25; ep++) begin
      i_rst = 1; i_enable = 0;
      for (int e = 0; e < 16; e++) begin
        snap[4:0] = 5'($urandom_range(0, 31));
        rom[e] = {(($urandom % 8) == 0) ? 5'd31 : 5'($urandom_range(0, 3)), snap[4:0]};
      end
      tick1(); i_rst = 0;
      for (int c = 0; c < 400; c++) begin
        tick1();
        quiet = int'($urandom % 256);
        i_enable = (quiet >= 4);
        i_rst = (quiet == 0) && (($urandom % 2) == 0);
      end
    end
    i_rst = 0; i_enable = 0;
    tick1(); tick1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
